// File: rtl/pipe_reg_file.sv
// pipe_reg_file: multi-port general-purpose register file for the pipelined MIPS core.
// Two write ports (port 1 has priority), NUM_RD combinational read ports with optional
// same-cycle write forwarding, and a per-register pending-write scoreboard with a
// registered count of outstanding reservations.
module pipe_reg_file #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
   output logic [NUM_RD*DATA_W-1:0]   rdata_o,
   output logic [NUM_RD-1:0]          busy_o,
   input  logic                       we0_i,
   input  logic [ADDR_W-1:0]          waddr0_i,
   input  logic [DATA_W-1:0]          wdata0_i,
   input  logic                       we1_i,
   input  logic [ADDR_W-1:0]          waddr1_i,
   input  logic [DATA_W-1:0]          wdata1_i,
   input  logic                       rsv_i,
   input  logic [ADDR_W-1:0]          rsv_addr_i,
   output logic [ADDR_W:0]            busy_cnt_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Flattened view of every register and busy bit, driven slice-by-slice below.
   logic [DEPTH*DATA_W-1:0] regs_flat;
   logic [DEPTH-1:0]        busy_vec;
   logic [DEPTH-1:0]        busy_nxt;
   logic [ADDR_W:0]         cnt_reg;
   logic [ADDR_W:0]         cnt_next;

   genvar gi;

   // One storage cell plus scoreboard bit per architectural register.
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         localparam logic [ADDR_W-1:0] ADDR = ADDR_W'(gi);
         // Register 0 is hard-wired when ZERO_REG is set: no writes, no reservations.
         localparam bit LIVE = !((ZERO_REG != 0) && (gi == 0));

         logic [DATA_W-1:0] data_reg;
         logic              busy_reg;
         logic              hit0;
         logic              hit1;
         logic              set;

         assign hit0 = LIVE && we0_i && (waddr0_i == ADDR);
         assign hit1 = LIVE && we1_i && (waddr1_i == ADDR);
         assign set  = LIVE && rsv_i && (rsv_addr_i == ADDR);

         // A new reservation beats a completing write to the same register.
         assign busy_nxt[gi] = set ? 1'b1 : ((hit0 || hit1) ? 1'b0 : busy_reg);

         // Data and busy state; port 1 overrides port 0 on an address collision.
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               data_reg <= '0;
               busy_reg <= 1'b0;
            end else begin
               if (hit1) begin
                  data_reg <= wdata1_i;
               end else if (hit0) begin
                  data_reg <= wdata0_i;
               end
               busy_reg <= busy_nxt[gi];
            end
         end

         assign regs_flat[gi*DATA_W +: DATA_W] = data_reg;
         assign busy_vec[gi]                   = busy_reg;
      end
   endgenerate

   // Reservation count is the population count of the next busy vector, so it can never wrap.
   always_comb begin
      cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_nxt[i]};
      end
   end

   // Registered reservation count.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign busy_cnt_o = cnt_reg;

   // Independent combinational read ports with optional write forwarding.
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] rd;
         logic              bz;
         logic              zero_addr;
         logic              fwd1;
         logic              fwd0;

         assign ra        = raddr_i[gi*ADDR_W +: ADDR_W];
         assign zero_addr = (ZERO_REG != 0) && (ra == '0);
         assign fwd1      = (BYPASS != 0) && !zero_addr && we1_i && (waddr1_i == ra);
         assign fwd0      = (BYPASS != 0) && !zero_addr && we0_i && (waddr0_i == ra);

         // Select forwarded or stored data; a completing write hides busy when forwarding.
         always_comb begin
            rd = regs_flat[ra*DATA_W +: DATA_W];
            bz = busy_vec[ra];
            if (fwd1) begin
               rd = wdata1_i;
            end else if (fwd0) begin
               rd = wdata0_i;
            end
            if (fwd0 || fwd1) begin
               bz = 1'b0;
            end
            if (zero_addr || !rst_i) begin
               rd = '0;
               bz = 1'b0;
            end
         end

         assign rdata_o[gi*DATA_W +: DATA_W] = rd;
         assign busy_o[gi]                   = bz;
      end
   endgenerate

endmodule

// File: doc/pipe_reg_file.md
Name: pipe_reg_file

Overview:
Parametrised multi-port general-purpose register file for the pipelined MIPS core; successor to the single-cycle two-read/one-write file.
- Configurable data width, depth and read-port count.
- Two write ports: WB stage and a secondary writer, e.g. the multiply/divide unit.
- Optional write-to-read bypass.
- Per-register pending-write scoreboard, which decode uses for load-use and long-latency stall detection.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns the pre-write array value
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and ignores reservations

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
raddr_i  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rdata_o  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
busy_o  out  NUM_RD  port k's addressed register has a pending write
we0_i  in  1  write port 0 enable (WB stage)
waddr0_i  in  ADDR_W  write port 0 address
wdata0_i  in  DATA_W  write port 0 data
we1_i  in  1  write port 1 enable (secondary writer)
waddr1_i  in  ADDR_W  write port 1 address
wdata1_i  in  DATA_W  write port 1 data
rsv_i  in  1  reserve: mark rsv_addr_i as pending a write
rsv_addr_i  in  ADDR_W  register to reserve
busy_cnt_o  out  ADDR_W+1  number of registers currently reserved

Behaviour:
- Reset (rst_i=0, asynchronous):
  - All registers clear to 0; all busy bits clear.
  - busy_cnt_o=0, busy_o=0.
  - rdata_o=0 for every address.
  - Reset mid-operation discards all pending writes and reservations immediately, without waiting for a clock edge.
- Read ports: combinational from raddr_i, zero latency, fully independent of one another.
- Writes: take effect on the rising clk_i edge when the enable is high; no response on any other edge.
- Both write ports to the same address in one cycle: port 1 wins and port 0 data is dropped.
- ZERO_REG=1: writes to address 0 are ignored, reads of address 0 return 0, busy for address 0 is always 0, and rsv_i to address 0 is ignored.
- Bypass, BYPASS=1, applies the write priority above:
  - rdata for port k = wdata1_i if we1_i && waddr1_i==raddr_k.
  - Else wdata0_i if we0_i && waddr0_i==raddr_k.
  - Else the array value.
  - Address 0 is never bypassed when ZERO_REG=1.
- Bypass, BYPASS=0: reads return the array value; the new value is visible the cycle after the write edge.
- Scoreboard busy bits, updated on the rising edge:
  - Any write (either port) to address a clears busy[a].
  - rsv_i sets busy[rsv_addr_i].
  - Set and clear of the same address in one cycle: set wins; the new reservation supersedes the old one.
  - rsv_i to an already-busy register: the bit stays 1 and busy_cnt_o is unchanged.
  - A write to a non-busy register leaves the busy bit and busy_cnt_o unchanged.
  - Writes are never blocked by busy state.
- busy_o[k]:
  - BYPASS=1: busy[raddr_k] && !(a write to raddr_k this cycle). A completing write de-asserts busy the same cycle.
  - BYPASS=0: busy[raddr_k] as registered.
- busy_cnt_o:
  - Registered; equals the popcount of the busy bits after each edge.
  - Per edge it changes by (newly set) minus (newly cleared), for a range of -2 to +1.
  - Maximum value: 2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1.
  - Never wraps.

Test Plan:
- Reset then read all 32 addresses -> all rdata 0, busy_o=0, busy_cnt_o=0. Assert rst_i low mid-run after writing r5=0x1234 -> r5 reads 0 immediately, before any clock edge.
- we0 r3=0xDEADBEEF and we1 r3=0x00000007 in the same cycle, BYPASS=1, raddr0=3 -> rdata0=0x7 in that cycle and 0x7 after the edge.
- BYPASS=0: write r8=0xA5A5A5A5 with raddr1=8 -> rdata1 keeps its old value (0) in that cycle and shows 0xA5A5A5A5 the next cycle.
- rsv r9, then 3 idle cycles, then we0 r9=0x55 -> busy_o for raddr=9 is 1 for 3 cycles; in the write cycle busy_o=0 and rdata=0x55 (BYPASS=1); busy_cnt_o goes 0→1→0.
- rsv r4 and we0 r4=0x11 in the same cycle -> after the edge r4=0x11, busy[4]=1, busy_cnt_o=1.
- we0 r0=0xFFFFFFFF and rsv r0 -> r0 reads 0, busy for r0 is 0, busy_cnt_o unchanged. Reserve r1-r31 one per cycle -> busy_cnt_o=31 and saturates there.
